// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between NUM_PORTS requesters using a valid/ready
// handshake, a fixed-latency response pipeline and fixed-priority or round-robin grant.
module mem_port_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 1,
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*3-1:0]        req_func3,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [2:0]                    mem_func3,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] owner_reg;
  logic             owner_we_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [SC_W-1:0]  starve_reg, starve_next;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [2:0]        func3_arr [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic             accept_win;
  logic             accept;
  logic             rd_capture;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign func3_arr[gi] = req_func3[gi*3 +: 3];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin walks offsets downward so the smallest offset from pointer+1 is written last.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (ARB_MODE == 1) begin
      for (int k = NUM_PORTS; k >= 1; k--) begin
        idx = (int'(rr_ptr_reg) + k) % NUM_PORTS;
        if (req_valid[idx]) begin
          grant_idx = IDX_W'(idx);
          grant_any = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req_valid[i]) begin
          grant_idx = IDX_W'(i);
          grant_any = 1'b1;
        end
      end
      if (STARVE_LIMIT > 0 && starve_reg == SC_W'(STARVE_LIMIT) && req_valid[0]) begin
        grant_idx = '0;
      end
    end
  end

  assign accept_win = (state_reg == IDLE) || (cnt_reg == '0);
  assign accept     = accept_win && grant_any && !rst;
  assign busy       = (state_reg == WAIT);

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
    if (state_reg == WAIT && cnt_reg == '0) begin
      rsp_valid[owner_reg] = 1'b1;
    end
  end

  assign mem_en    = accept;
  assign mem_we    = req_we[grant_idx];
  assign mem_addr  = addr_arr[grant_idx];
  assign mem_func3 = func3_arr[grant_idx];
  assign mem_wdata = wdata_arr[grant_idx];

  // Read data is sampled in the cycle the memory presents it: the accept cycle when
  // the memory is combinational, otherwise the cycle just before the response.
  assign rd_capture = (LATENCY == 1) ? (accept && !mem_we)
                                     : (state_reg == WAIT && cnt_reg == CNT_W'(1) && !owner_we_reg);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      state_next = WAIT;
      cnt_next   = CNT_W'(LATENCY - 1);
    end else if (state_reg == WAIT) begin
      if (cnt_reg == '0) begin
        state_next = IDLE;
      end else begin
        cnt_next = cnt_reg - CNT_W'(1);
      end
    end
  end

  always_comb begin
    starve_next = starve_reg;
    if (ARB_MODE == 0 && STARVE_LIMIT > 0) begin
      if (!req_valid[0]) begin
        starve_next = '0;
      end else if (accept_win) begin
        if (accept && grant_idx == '0) begin
          starve_next = '0;
        end else if (starve_reg != SC_W'(STARVE_LIMIT)) begin
          starve_next = starve_reg + SC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      owner_reg    <= '0;
      owner_we_reg <= 1'b0;
      rr_ptr_reg   <= IDX_W'(NUM_PORTS - 1);
      starve_reg   <= '0;
      rsp_rdata    <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      starve_reg <= starve_next;
      if (accept) begin
        owner_reg    <= grant_idx;
        owner_we_reg <= mem_we;
        rr_ptr_reg   <= grant_idx;
      end
      if (rd_capture) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: five instances cover fixed priority, multi-cycle
// latency with a memory model, round-robin, starvation promotion and mid-transaction reset.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 ports, LATENCY 1, fixed priority
  logic [1:0]  a_valid, a_we, a_ready, a_rspv;
  logic [15:0] a_addr;
  logic [5:0]  a_f3;
  logic [63:0] a_wd;
  logic [31:0] a_rd, a_mwd, a_mrd;
  logic        a_men, a_mwe, a_busy;
  logic [7:0]  a_maddr;
  logic [2:0]  a_mf3;
  assign a_mrd = 32'hA5A5_0000 | {24'h0, a_maddr};

  mem_port_arbiter #(.NUM_PORTS(2), .LATENCY(1), .ARB_MODE(0), .STARVE_LIMIT(0)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
    .req_func3(a_f3), .req_wdata(a_wd), .req_ready(a_ready), .rsp_valid(a_rspv),
    .rsp_rdata(a_rd), .mem_en(a_men), .mem_we(a_mwe), .mem_addr(a_maddr),
    .mem_func3(a_mf3), .mem_wdata(a_mwd), .mem_rdata(a_mrd), .busy(a_busy));

  // Instance B: 2 ports, LATENCY 3, backed by a pipelined memory model
  logic [1:0]  b_valid, b_we, b_ready, b_rspv;
  logic [15:0] b_addr;
  logic [5:0]  b_f3;
  logic [63:0] b_wd;
  logic [31:0] b_rd, b_mwd, b_mrd, b_p1, b_p2;
  logic        b_men, b_mwe, b_busy;
  logic [7:0]  b_maddr;
  logic [2:0]  b_mf3;
  logic [31:0] b_mem [0:255];
  always @(posedge clk) begin
    if (b_men) begin
      if (b_mwe) b_mem[b_maddr] <= b_mwd;
      b_p1 <= b_mem[b_maddr];
    end
    b_p2 <= b_p1;
  end
  assign b_mrd = b_p2;

  mem_port_arbiter #(.NUM_PORTS(2), .LATENCY(3), .ARB_MODE(0), .STARVE_LIMIT(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
    .req_func3(b_f3), .req_wdata(b_wd), .req_ready(b_ready), .rsp_valid(b_rspv),
    .rsp_rdata(b_rd), .mem_en(b_men), .mem_we(b_mwe), .mem_addr(b_maddr),
    .mem_func3(b_mf3), .mem_wdata(b_mwd), .mem_rdata(b_mrd), .busy(b_busy));

  // Instance C: 4 ports, LATENCY 1, round-robin
  logic [3:0]   c_valid, c_we, c_ready, c_rspv;
  logic [31:0]  c_addr;
  logic [11:0]  c_f3;
  logic [127:0] c_wd;
  logic [31:0]  c_rd, c_mwd;
  logic         c_men, c_mwe, c_busy;
  logic [7:0]   c_maddr;
  logic [2:0]   c_mf3;

  mem_port_arbiter #(.NUM_PORTS(4), .LATENCY(1), .ARB_MODE(1), .STARVE_LIMIT(0)) u_c (
    .clk(clk), .rst(rst), .req_valid(c_valid), .req_we(c_we), .req_addr(c_addr),
    .req_func3(c_f3), .req_wdata(c_wd), .req_ready(c_ready), .rsp_valid(c_rspv),
    .rsp_rdata(c_rd), .mem_en(c_men), .mem_we(c_mwe), .mem_addr(c_maddr),
    .mem_func3(c_mf3), .mem_wdata(c_mwd), .mem_rdata(32'h0000_0C0C), .busy(c_busy));

  // Instance D: 2 ports, LATENCY 1, fixed priority with starvation limit 3
  logic [1:0]  d_valid, d_we, d_ready, d_rspv;
  logic [15:0] d_addr;
  logic [5:0]  d_f3;
  logic [63:0] d_wd;
  logic [31:0] d_rd, d_mwd;
  logic        d_men, d_mwe, d_busy;
  logic [7:0]  d_maddr;
  logic [2:0]  d_mf3;

  mem_port_arbiter #(.NUM_PORTS(2), .LATENCY(1), .ARB_MODE(0), .STARVE_LIMIT(3)) u_d (
    .clk(clk), .rst(rst), .req_valid(d_valid), .req_we(d_we), .req_addr(d_addr),
    .req_func3(d_f3), .req_wdata(d_wd), .req_ready(d_ready), .rsp_valid(d_rspv),
    .rsp_rdata(d_rd), .mem_en(d_men), .mem_we(d_mwe), .mem_addr(d_maddr),
    .mem_func3(d_mf3), .mem_wdata(d_mwd), .mem_rdata(32'h0000_0D0D), .busy(d_busy));

  // Instance E: 2 ports, LATENCY 4, used for the mid-transaction reset
  logic [1:0]  e_valid, e_we, e_ready, e_rspv;
  logic [15:0] e_addr;
  logic [5:0]  e_f3;
  logic [63:0] e_wd;
  logic [31:0] e_rd, e_mwd;
  logic        e_men, e_mwe, e_busy;
  logic [7:0]  e_maddr;
  logic [2:0]  e_mf3;

  mem_port_arbiter #(.NUM_PORTS(2), .LATENCY(4), .ARB_MODE(0), .STARVE_LIMIT(0)) u_e (
    .clk(clk), .rst(rst), .req_valid(e_valid), .req_we(e_we), .req_addr(e_addr),
    .req_func3(e_f3), .req_wdata(e_wd), .req_ready(e_ready), .rsp_valid(e_rspv),
    .rsp_rdata(e_rd), .mem_en(e_men), .mem_we(e_mwe), .mem_addr(e_maddr),
    .mem_func3(e_mf3), .mem_wdata(e_mwd), .mem_rdata(32'h1234_5678), .busy(e_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    logic [1:0] st_exp [8];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    st_exp = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    vectors = 0;
    miscompares = 0;
    a_valid = '0; a_we = '0; a_addr = '0; a_f3 = {3'b010, 3'b100}; a_wd = '0;
    b_valid = '0; b_we = '0; b_addr = '0; b_f3 = {3'b010, 3'b010}; b_wd = '0;
    c_valid = '0; c_we = '0; c_addr = '0; c_f3 = '0; c_wd = '0;
    d_valid = '0; d_we = '0; d_addr = '0; d_f3 = '0; d_wd = '0;
    e_valid = '0; e_we = '0; e_addr = '0; e_f3 = '0; e_wd = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("reset a_ready", 32'(a_ready), 32'h0);
    check("reset a_rspv", 32'(a_rspv), 32'h0);
    check("reset a_rdata", a_rd, 32'h0);
    check("reset a_mem_en", 32'(a_men), 32'h0);
    check("reset a_busy", 32'(a_busy), 32'h0);
    check("reset c_ready", 32'(c_ready), 32'h0);

    // Fixed priority, LATENCY 1: both ports read in the same cycle
    @(negedge clk); a_valid = 2'b11; a_addr = {8'h20, 8'h10}; #1;
    check("A1 ready", 32'(a_ready), 32'h2);
    check("A1 mem_en", 32'(a_men), 32'h1);
    check("A1 mem_addr", 32'(a_maddr), 32'h20);
    check("A1 mem_func3", 32'(a_mf3), 32'h2);
    check("A1 mem_we", 32'(a_mwe), 32'h0);
    @(negedge clk); a_valid = 2'b01; #1;
    check("A2 rspv", 32'(a_rspv), 32'h2);
    check("A2 rdata", a_rd, 32'hA5A5_0020);
    check("A2 ready", 32'(a_ready), 32'h1);
    check("A2 mem_addr", 32'(a_maddr), 32'h10);
    check("A2 mem_func3", 32'(a_mf3), 32'h4);
    check("A2 busy", 32'(a_busy), 32'h1);
    @(negedge clk); a_valid = 2'b00; #1;
    check("A3 rspv", 32'(a_rspv), 32'h1);
    check("A3 rdata", a_rd, 32'hA5A5_0010);
    check("A3 ready", 32'(a_ready), 32'h0);
    @(negedge clk); #1;
    check("A4 rspv", 32'(a_rspv), 32'h0);
    check("A4 busy", 32'(a_busy), 32'h0);
    // Write acknowledge leaves rsp_rdata untouched
    @(negedge clk); a_valid = 2'b01; a_we = 2'b01; a_addr = {8'h00, 8'h30}; a_wd = {32'h0, 32'h1111_2222}; #1;
    check("A5 ready", 32'(a_ready), 32'h1);
    check("A5 mem_we", 32'(a_mwe), 32'h1);
    check("A5 mem_wdata", a_mwd, 32'h1111_2222);
    check("A5 mem_addr", 32'(a_maddr), 32'h30);
    @(negedge clk); a_valid = 2'b00; a_we = 2'b00; #1;
    check("A6 rspv", 32'(a_rspv), 32'h1);
    check("A6 rdata", a_rd, 32'hA5A5_0010);

    // LATENCY 3: port 1 writes 0xDEADBEEF to 0x40, then reads it back
    @(negedge clk); b_valid = 2'b10; b_we = 2'b10; b_addr = {8'h40, 8'h00}; b_wd = {32'hDEAD_BEEF, 32'h0}; #1;
    check("B1 ready", 32'(b_ready), 32'h2);
    check("B1 mem_we", 32'(b_mwe), 32'h1);
    check("B1 mem_addr", 32'(b_maddr), 32'h40);
    check("B1 mem_wdata", b_mwd, 32'hDEAD_BEEF);
    @(negedge clk); b_we = 2'b00; #1;
    check("B2 ready", 32'(b_ready), 32'h0);
    check("B2 busy", 32'(b_busy), 32'h1);
    check("B2 rspv", 32'(b_rspv), 32'h0);
    @(negedge clk); #1;
    check("B3 ready", 32'(b_ready), 32'h0);
    check("B3 rspv", 32'(b_rspv), 32'h0);
    @(negedge clk); #1;
    check("B4 rspv", 32'(b_rspv), 32'h2);
    check("B4 ready", 32'(b_ready), 32'h2);
    check("B4 rdata", b_rd, 32'h0);
    @(negedge clk); b_valid = 2'b00; #1;
    check("B5 ready", 32'(b_ready), 32'h0);
    check("B5 rspv", 32'(b_rspv), 32'h0);
    @(negedge clk); #1;
    check("B6 rspv", 32'(b_rspv), 32'h0);
    @(negedge clk); #1;
    check("B7 rspv", 32'(b_rspv), 32'h2);
    check("B7 rdata", b_rd, 32'hDEAD_BEEF);
    check("B7 busy", 32'(b_busy), 32'h1);
    @(negedge clk); #1;
    check("B8 busy", 32'(b_busy), 32'h0);
    check("B8 rspv", 32'(b_rspv), 32'h0);

    // Round-robin, all four ports requesting continuously
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); c_valid = 4'hF; #1;
      check($sformatf("C grant %0d", k), 32'(c_ready), 32'(rr_exp[k]));
      if (k > 0) check($sformatf("C rspv %0d", k), 32'(c_rspv), 32'(rr_exp[k-1]));
    end
    @(negedge clk); c_valid = 4'h0; #1;
    check("C rspv tail", 32'(c_rspv), 32'h1);
    @(negedge clk); #1;
    @(negedge clk); c_valid = 4'b0110; #1;
    check("C ptr held idle", 32'(c_ready), 32'h2);
    @(negedge clk); c_valid = 4'h0; #1;

    // Fixed priority with starvation promotion of port 0 after 3 denials
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); d_valid = 2'b11; #1;
      check($sformatf("D grant %0d", k), 32'(d_ready), 32'(st_exp[k]));
    end
    @(negedge clk); d_valid = 2'b00; #1;

    // LATENCY 4: reset while the transaction is outstanding drops it
    @(negedge clk); e_valid = 2'b01; e_addr = {8'h00, 8'h08}; #1;
    check("E1 ready", 32'(e_ready), 32'h1);
    @(negedge clk); e_valid = 2'b00; #1;
    check("E2 busy", 32'(e_busy), 32'h1);
    check("E2 ready", 32'(e_ready), 32'h0);
    @(negedge clk); rst = 1'b1; #1;
    check("E3 busy", 32'(e_busy), 32'h1);
    @(negedge clk); rst = 1'b0; e_valid = 2'b10; #1;
    check("E4 rspv", 32'(e_rspv), 32'h0);
    check("E4 busy", 32'(e_busy), 32'h0);
    check("E4 ready", 32'(e_ready), 32'h2);
    @(negedge clk); e_valid = 2'b00; #1;
    check("E5 dropped rspv", 32'(e_rspv), 32'h0);
    check("E5 busy", 32'(e_busy), 32'h1);
    repeat (3) @(negedge clk);
    #1;
    check("E8 rspv", 32'(e_rspv), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
